// File: rtl/sequential_nonrestoring_divider_128bit_pkg.sv
// Shared constants and FSM encoding for the 128-bit non-restoring divider.
package sequential_nonrestoring_divider_128bit_pkg;

    localparam int unsigned DIV_WIDTH  = 128;
    localparam int unsigned ITER_COUNT = DIV_WIDTH;

    typedef enum logic [2:0] {
        StLoad    = 3'd0,
        StIter    = 3'd1,
        StCorrect = 3'd2,
        StDone    = 3'd3
    } div_state_e;

endpackage

// File: rtl/sequential_nonrestoring_divider_128bit_nrd_addsub.sv
// (WIDTH+1)-bit add/subtract of the zero-extended divisor against the partial remainder.
module sequential_nonrestoring_divider_128bit_nrd_addsub #(
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   result_o
);

    logic [WIDTH:0] m_ext;

    always_comb begin
        m_ext    = {1'b0, m_i};
        result_o = sub_i ? (a_i - m_ext) : (a_i + m_ext);
    end

endmodule

// File: rtl/sequential_nonrestoring_divider_128bit.sv
// Unsigned sequential non-restoring divider, one quotient bit per clock; a reset pulse starts
// each division. Optional macro DIV_BY_ZERO_DETECT_EN adds a div_by_zero output and fast path.
module sequential_nonrestoring_divider_128bit
    import sequential_nonrestoring_divider_128bit_pkg::*;
#(
    parameter int unsigned WIDTH = ITER_COUNT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         dividend_q,
    input  logic [WIDTH-1:0]         divisor_m,
    output logic [WIDTH-1:0]         quotient,
    output logic [WIDTH-1:0]         remainder,
    output logic                     done,
`ifdef DIV_BY_ZERO_DETECT_EN
    output logic                     div_by_zero,
`endif
    output logic [2:0]               state_out,
    output logic [$clog2(WIDTH):0]   count_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
`ifdef DIV_BY_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH:0]   as_operand;
    logic             as_sub;
    logic [WIDTH:0]   as_result;
    logic [WIDTH:0]   a_shift;

    sequential_nonrestoring_divider_128bit_nrd_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i      (as_operand),
        .m_i      (m_q),
        .sub_i    (as_sub),
        .result_o (as_result)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        done_d     = done_q;
`ifdef DIV_BY_ZERO_DETECT_EN
        dbz_d      = dbz_q;
`endif
        a_shift    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        as_operand = a_q;
        as_sub     = 1'b0;

        unique case (state_q)
            StLoad: begin
                a_d     = '0;
                q_d     = dividend_q;
                m_d     = divisor_m;
                count_d = '0;
                state_d = StIter;
`ifdef DIV_BY_ZERO_DETECT_EN
                // Preload the final answer and let CORRECT publish it (M=0 adds nothing).
                if (divisor_m == '0) begin
                    a_d     = {1'b0, dividend_q};
                    q_d     = '1;
                    dbz_d   = 1'b1;
                    state_d = StCorrect;
                end
`endif
            end
            StIter: begin
                // Subtract while the partial remainder is non-negative, add back otherwise.
                as_operand = a_shift;
                as_sub     = ~a_q[WIDTH];
                a_d        = as_result;
                q_d        = {q_q[WIDTH-2:0], ~as_result[WIDTH]};
                count_d    = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = StCorrect;
                end
            end
            StCorrect: begin
                as_operand = a_q;
                as_sub     = 1'b0;
                a_d        = a_q[WIDTH] ? as_result : a_q;
                quot_d     = q_q;
                rem_d      = a_d[WIDTH-1:0];
                done_d     = 1'b1;
                state_d    = StDone;
            end
            StDone: begin
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= StLoad;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    always_comb begin
        quotient  = quot_q;
        remainder = rem_q;
        done      = done_q;
        state_out = state_q;
        count_out = count_q;
`ifdef DIV_BY_ZERO_DETECT_EN
        div_by_zero = dbz_q;
`endif
    end

endmodule

// File: tb/tb_sequential_nonrestoring_divider_128bit.sv
// Directed self-checking bench for the 128-bit sequential non-restoring divider.
module tb_sequential_nonrestoring_divider_128bit;

    localparam int unsigned W = 128;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] dividend_q;
    logic [W-1:0] divisor_m;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic [2:0]   state_out;
    logic [7:0]   count_out;
`ifdef DIV_BY_ZERO_DETECT_EN
    logic         div_by_zero;
`endif

    int checks   = 0;
    int failures = 0;

    sequential_nonrestoring_divider_128bit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dividend_q (dividend_q),
        .divisor_m  (divisor_m),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
`ifdef DIV_BY_ZERO_DETECT_EN
        .div_by_zero(div_by_zero),
`endif
        .state_out  (state_out),
        .count_out  (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset edge, then release and clock until done; lat counts edges after release.
    task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit trace,
                           output int lat);
        int exp_state;
        int exp_count;
        dividend_q = dd;
        divisor_m  = dv;
        reset_n    = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        lat     = 0;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (trace) begin
                exp_state = (lat <= 128) ? 1 : ((lat == 129) ? 2 : 3);
                exp_count = (lat == 1) ? 0 : ((lat <= 129) ? lat - 1 : 128);
                chk($sformatf("trace_state@%0d", lat), W'(state_out), W'(exp_state));
                chk($sformatf("trace_count@%0d", lat), W'(count_out), W'(exp_count));
                if (!done) chk($sformatf("trace_quot_zero@%0d", lat), quotient, '0);
            end
        end
    endtask

    initial begin
        int lat;
        int wait_cnt;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        int dv_list [8] = '{1, 3, 7, 15, 31, 63, 127, 255};

        reset_n    = 1'b1;
        dividend_q = '0;
        divisor_m  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", W'(state_out), W'(0));
        chk("rst_count", W'(count_out), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_quot", quotient, '0);
        chk("rst_rem", remainder, '0);

        // 4294967295 / 25 with full state/count trace.
        run_div(W'(64'd4294967295), W'(25), 1'b1, lat);
        chk("big_lat", W'(lat), W'(130));
        chk("big_quot", quotient, W'(64'd171798691));
        chk("big_rem", remainder, W'(20));
        chk("big_state", W'(state_out), W'(3));

        // Results hold while reset stays low.
        dividend_q = W'(999);
        divisor_m  = W'(2);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_done", W'(done), W'(1));
        chk("hold_quot", quotient, W'(64'd171798691));
        chk("hold_rem", remainder, W'(20));
        chk("hold_count", W'(count_out), W'(128));

        // Named small cases.
        run_div(W'(200), W'(63), 1'b0, lat);
        chk("200_63_q", quotient, W'(3));
        chk("200_63_r", remainder, W'(11));
        run_div(W'(255), W'(127), 1'b0, lat);
        chk("255_127_q", quotient, W'(2));
        chk("255_127_r", remainder, W'(1));
        run_div(W'(0), W'(1), 1'b0, lat);
        chk("0_1_q", quotient, W'(0));
        chk("0_1_r", remainder, W'(0));

        // Strided sweep against the language's own divide.
        for (int dd = 0; dd < 256; dd += 17) begin
            for (int k = 0; k < 8; k++) begin
                exp_q = W'(dd / dv_list[k]);
                exp_r = W'(dd % dv_list[k]);
                run_div(W'(dd), W'(dv_list[k]), 1'b0, lat);
                chk($sformatf("sweep_q_%0d_%0d", dd, dv_list[k]), quotient, exp_q);
                chk($sformatf("sweep_r_%0d_%0d", dd, dv_list[k]), remainder, exp_r);
            end
        end

        // Extremes.
        run_div('1, W'(1), 1'b0, lat);
        chk("max_1_q", quotient, '1);
        chk("max_1_r", remainder, '0);
        run_div(W'(5), W'(7), 1'b0, lat);
        chk("5_7_q", quotient, W'(0));
        chk("5_7_r", remainder, W'(5));

        // Divide by zero.
        run_div(W'(5), W'(0), 1'b0, lat);
`ifdef DIV_BY_ZERO_DETECT_EN
        chk("dz_lat", W'(lat), W'(2));
        chk("dz_flag", W'(div_by_zero), W'(1));
`else
        chk("dz_lat", W'(lat), W'(130));
`endif
        chk("dz_q", quotient, '1);
        chk("dz_r", remainder, W'(5));

        // Abort mid-operation at count 50, restart with new operands.
        dividend_q = W'(1000);
        divisor_m  = W'(7);
        reset_n    = 1'b1;
        @(posedge clk); #1;
        reset_n  = 1'b0;
        wait_cnt = 0;
        while (count_out != 8'd50 && wait_cnt < 200) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("abort_reach50", W'(count_out), W'(50));
        chk("abort_not_done", W'(done), W'(0));
        dividend_q = W'(100);
        divisor_m  = W'(9);
        reset_n    = 1'b1;
        @(posedge clk); #1;
        chk("abort_rst_count", W'(count_out), W'(0));
        chk("abort_rst_state", W'(state_out), W'(0));
        chk("abort_rst_quot", quotient, '0);
        run_div(W'(100), W'(9), 1'b1, lat);
        chk("abort_lat", W'(lat), W'(130));
        chk("abort_q", quotient, W'(11));
        chk("abort_r", remainder, W'(1));

        // Reset after completion clears the held result.
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", W'(done), W'(0));
        chk("post_rst_quot", quotient, '0);
        chk("post_rst_rem", remainder, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
